// File: rtl/caliptra_prim_esc_pkg.sv
// Shared types for the differential escalation link: wire pairs, idle values
// and the receiver state encoding.
package caliptra_prim_esc_pkg;

    // Request pair driven by the escalation sender.
    typedef struct packed {
        logic esc_p;
        logic esc_n;
    } esc_tx_t;

    // Response pair returned to the sender.
    typedef struct packed {
        logic resp_p;
        logic resp_n;
    } esc_rx_t;

    localparam esc_tx_t ESC_TX_DEFAULT = '{esc_p: 1'b0, esc_n: 1'b1};
    localparam esc_rx_t ESC_RX_DEFAULT = '{resp_p: 1'b0, resp_n: 1'b1};

    localparam int unsigned StateWidth = 6;

    // Pairwise Hamming distance >= 3 so a single flipped bit cannot land in
    // another legal state.
    typedef enum logic [StateWidth-1:0] {
        Idle     = 6'b000111,
        Check    = 6'b011100,
        PingResp = 6'b101010,
        EscResp  = 6'b110001,
        SigInt   = 6'b111111
    } esc_state_e;

endpackage

// File: rtl/caliptra_prim_diff_decode.sv
// Differential pair decoder for a pair that shares the receiver's clock.
// No skew is tolerated, so any cycle with equal wires is an integrity error.
//   diff_p, diff_n : differential input pair
//   level_c        : decoded logic level (the positive wire)
//   sigint_c       : both wires equal
module caliptra_prim_diff_decode (
    input  logic diff_p,
    input  logic diff_n,
    output logic level_c,
    output logic sigint_c
);

    assign level_c  = diff_p;
    assign sigint_c = (diff_p == diff_n);

endmodule

// File: rtl/caliptra_prim_esc_receiver.sv
// Receiving end of the differential escalation link. Separates pings
// (one-cycle pulses) from escalations (pulses of two or more cycles), answers
// with the differential response pattern the sender checks, and requests
// escalation locally on escalation, integrity failure or ping timeout.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   esc_tx_i  : {esc_p, esc_n} from the sender
//   esc_rx_o  : {resp_p, resp_n} to the sender
//   esc_req_o : escalation request to local logic
module caliptra_prim_esc_receiver
    import caliptra_prim_esc_pkg::*;
#(
    parameter bit          TimeoutEn    = 1'b1,
    parameter int unsigned TimeoutCntDw = 16
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  esc_tx_t esc_tx_i,
    output esc_rx_t esc_rx_o,
    output logic    esc_req_o
);

    localparam logic [TimeoutCntDw-1:0] CntMax = '1;

    logic level_c;
    logic sigint_c;

    caliptra_prim_diff_decode u_decode (
        .diff_p   (esc_tx_i.esc_p),
        .diff_n   (esc_tx_i.esc_n),
        .level_c  (level_c),
        .sigint_c (sigint_c)
    );

    esc_state_e              state_q, state_d;
    logic                    resp_p_q, resp_p_d;
    logic                    resp_n_q, resp_n_d;
    logic                    esc_q, esc_d;
    logic                    ping_done_c;
    logic                    cnt_sat_c;
    logic [TimeoutCntDw-1:0] cnt_q, cnt_d;

    // Next state and response; integrity failure overrides the level.
    always_comb begin
        state_d     = state_q;
        resp_p_d    = ESC_RX_DEFAULT.resp_p;
        resp_n_d    = ESC_RX_DEFAULT.resp_n;
        esc_d       = 1'b0;
        ping_done_c = 1'b0;

        if (sigint_c) begin
            // Equal, toggling response so the sender also sees the failure.
            state_d  = SigInt;
            resp_p_d = ~resp_p_q;
            resp_n_d = ~resp_p_q;
            esc_d    = 1'b1;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (level_c) begin
                        state_d  = Check;
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end
                end
                Check: begin
                    if (level_c) begin
                        state_d = EscResp;
                        esc_d   = 1'b1;
                    end else begin
                        state_d     = PingResp;
                        ping_done_c = 1'b1;
                    end
                end
                PingResp: begin
                    if (level_c) begin
                        // New request before the ping handshake finished.
                        state_d  = SigInt;
                        resp_p_d = ~resp_p_q;
                        resp_n_d = ~resp_p_q;
                        esc_d    = 1'b1;
                    end else begin
                        state_d  = Idle;
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end
                end
                EscResp, SigInt: begin
                    if (level_c) begin
                        state_d  = EscResp;
                        resp_p_d = ~resp_p_q;
                        resp_n_d = resp_p_q;
                        esc_d    = 1'b1;
                    end else begin
                        state_d = Idle;
                    end
                end
                default: begin
                    state_d  = SigInt;
                    resp_p_d = ~resp_p_q;
                    resp_n_d = ~resp_p_q;
                    esc_d    = 1'b1;
                end
            endcase
        end
    end

    // Ping timeout: saturation is sticky, a completed ping restarts the count.
    always_comb begin
        cnt_sat_c = (cnt_q == CntMax);
        cnt_d     = cnt_q;
        if (!TimeoutEn) begin
            cnt_d = '0;
        end else if (cnt_sat_c) begin
            cnt_d = cnt_q;
        end else if (ping_done_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TimeoutCntDw'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            resp_p_q <= ESC_RX_DEFAULT.resp_p;
            resp_n_q <= ESC_RX_DEFAULT.resp_n;
            esc_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            resp_p_q <= resp_p_d;
            resp_n_q <= resp_n_d;
            esc_q    <= esc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign esc_rx_o  = '{resp_p: resp_p_q, resp_n: resp_n_q};
    assign esc_req_o = esc_q | (TimeoutEn & cnt_sat_c);

endmodule

// File: tb/tb_caliptra_prim_esc_receiver.sv
// Scoreboard bench for the escalation receiver. Each driven cycle pushes the
// response expected one edge later; it is popped and compared after the edge.
module tb_caliptra_prim_esc_receiver;
    import caliptra_prim_esc_pkg::*;

    typedef struct {
        logic [1:0] rx;
        logic       req;
    } exp_t;

    logic    clk;
    logic    rst_n;
    logic    rst_to;
    esc_tx_t tx;
    esc_tx_t tx_to;
    esc_rx_t rx, rx_off, rx_to;
    logic    req, req_off, req_to;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];
    logic to_q[$];

    // Main receiver: timeout enabled, wide counter (never saturates here).
    caliptra_prim_esc_receiver #(.TimeoutEn(1'b1), .TimeoutCntDw(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .esc_tx_i(tx), .esc_rx_o(rx), .esc_req_o(req)
    );

    // Timeout disabled with a narrow counter: must never request.
    caliptra_prim_esc_receiver #(.TimeoutEn(1'b0), .TimeoutCntDw(4)) dut_off (
        .clk_i(clk), .rst_ni(rst_n), .esc_tx_i(tx), .esc_rx_o(rx_off), .esc_req_o(req_off)
    );

    // Timeout enabled, saturates after 15 cycles.
    caliptra_prim_esc_receiver #(.TimeoutEn(1'b1), .TimeoutCntDw(4)) dut_to (
        .clk_i(clk), .rst_ni(rst_to), .esc_tx_i(tx_to), .esc_rx_o(rx_to), .esc_req_o(req_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive main inputs for one edge; e = {resp_p, resp_n, esc_req} after it.
    task automatic cyc(input logic ep, input logic en, input logic rv,
                       input logic [2:0] e, input string tag);
        exp_t x;
        tx    = '{esc_p: ep, esc_n: en};
        rst_n = rv;
        x.rx  = e[2:1];
        x.req = e[0];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check({tag, "_rx"}, 32'(rx), 32'(x.rx));
        check({tag, "_req"}, 32'(req), 32'(x.req));
    endtask

    // Drive the timeout instance for one edge; e = esc_req after it.
    task automatic to_cyc(input logic ep, input logic en, input logic rv,
                          input logic e, input string tag);
        logic x;
        tx_to  = '{esc_p: ep, esc_n: en};
        rst_to = rv;
        to_q.push_back(e);
        @(posedge clk);
        #1;
        x = to_q.pop_front();
        check(tag, 32'(req_to), 32'(x));
    endtask

    initial begin
        tx     = ESC_TX_DEFAULT;
        tx_to  = ESC_TX_DEFAULT;
        rst_n  = 1'b0;
        rst_to = 1'b0;

        // Reset state.
        cyc(1'b0, 1'b1, 1'b0, 3'b010, "reset");
        cyc(1'b0, 1'b1, 1'b0, 3'b010, "reset");

        // Long idle; the disabled-timeout instance must stay quiet.
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 3'b010, "idle");
            check("idle_off_rx", 32'(rx_off), 32'h1);
            check("idle_off_req", 32'(req_off), 32'h0);
        end

        // Ping: resp_p 1,0,1,0 then idle, no request, counter cleared.
        cyc(1'b1, 1'b0, 1'b1, 3'b100, "ping1");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "ping2");
        check("ping_cnt", 32'(dut.cnt_q), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 3'b100, "ping3");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "ping4");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "ping5");

        // Escalation held 6 cycles.
        cyc(1'b1, 1'b0, 1'b1, 3'b100, "esc1");
        cyc(1'b1, 1'b0, 1'b1, 3'b011, "esc2");
        cyc(1'b1, 1'b0, 1'b1, 3'b101, "esc3");
        cyc(1'b1, 1'b0, 1'b1, 3'b011, "esc4");
        cyc(1'b1, 1'b0, 1'b1, 3'b101, "esc5");
        cyc(1'b1, 1'b0, 1'b1, 3'b011, "esc6");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "esc_end");

        // Integrity failure for 2 cycles, then back to idle.
        cyc(1'b1, 1'b1, 1'b1, 3'b111, "sig1");
        cyc(1'b1, 1'b1, 1'b1, 3'b001, "sig2");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "sig_end");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "sig_idle");

        // Integrity failure resolving into an escalation keeps the request.
        cyc(1'b1, 1'b1, 1'b1, 3'b111, "sigesc1");
        cyc(1'b1, 1'b0, 1'b1, 3'b011, "sigesc2");
        cyc(1'b1, 1'b0, 1'b1, 3'b101, "sigesc3");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "sigesc_end");

        // Ping collision: request again while in PingResp.
        cyc(1'b1, 1'b0, 1'b1, 3'b100, "coll1");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "coll2");
        cyc(1'b1, 1'b0, 1'b1, 3'b111, "coll3");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "coll_end");

        // Reset during an escalation.
        cyc(1'b1, 1'b0, 1'b1, 3'b100, "rstesc1");
        cyc(1'b1, 1'b0, 1'b1, 3'b011, "rstesc2");
        cyc(1'b1, 1'b0, 1'b0, 3'b010, "rstesc_rst");
        cyc(1'b0, 1'b1, 1'b1, 3'b010, "rstesc_idle");

        // Timeout: request from the 15th edge after reset release.
        to_cyc(1'b0, 1'b1, 1'b0, 1'b0, "to_reset");
        for (int k = 1; k <= 20; k++)
            to_cyc(1'b0, 1'b1, 1'b1, (k >= 15), "to_count");
        // A ping after saturation does not clear it.
        to_cyc(1'b1, 1'b0, 1'b1, 1'b1, "to_ping1");
        to_cyc(1'b0, 1'b1, 1'b1, 1'b1, "to_ping2");
        for (int k = 0; k < 3; k++)
            to_cyc(1'b0, 1'b1, 1'b1, 1'b1, "to_sticky");
        to_cyc(1'b0, 1'b1, 1'b0, 1'b0, "to_rstclr");

        // Ping completing on the edge that would saturate: the clear wins.
        for (int k = 1; k <= 13; k++)
            to_cyc(1'b0, 1'b1, 1'b1, 1'b0, "to_pre");
        to_cyc(1'b1, 1'b0, 1'b1, 1'b0, "to_race14");
        to_cyc(1'b0, 1'b1, 1'b1, 1'b0, "to_race15");
        check("to_race_cnt", 32'(dut_to.cnt_q), 32'h0);
        for (int k = 16; k <= 30; k++)
            to_cyc(1'b0, 1'b1, 1'b1, (k == 30), "to_recount");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
